ex_div_sequencer: RTL and testbench

//  Multi-cycle controller for DIV/DIVU in the EX stage, beside the single-cycle ALU units.

---
 rtl/ex_div_sequencer.sv | 136 +++++++++++++
 tb/tb_ex_div_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: radix-2 restoring divider,
// one quotient bit per cycle, holding the pipeline via stallReq until done.
module ex_div_sequencer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             signedOp,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallReq,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     dq_q, dq_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     prem_q, prem_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     rem_q, rem_d;

    logic [WIDTH-1:0]     dividend_mag, divisor_mag;
    logic [WIDTH:0]       shifted;
    logic                 no_borrow;
    logic [WIDTH-1:0]     prem_step, dq_step;

    assign dividend_mag = (signedOp && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (signedOp && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The shifted remainder needs the extra bit: the partial remainder can have its
    // MSB set when the divisor exceeds half range. When no borrow occurs the true
    // difference is below the divisor, so a WIDTH-bit subtraction is exact.
    assign shifted   = {prem_q, dq_q[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, dvs_q});
    assign prem_step = no_borrow ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    assign dq_step   = {dq_q[WIDTH-2:0], no_borrow};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;

        if (cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            quot_d  = '0;
                            rem_d   = '0;
                        end else begin
                            state_d = S_BUSY;
                            dq_d    = dividend_mag;
                            dvs_d   = divisor_mag;
                            prem_d  = '0;
                            cnt_d   = '0;
                            q_neg_d = signedOp & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_d = signedOp & dividend[WIDTH-1];
                        end
                    end
                end
                S_BUSY: begin
                    dq_d   = dq_step;
                    prem_d = prem_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = q_neg_q ? -dq_step : dq_step;
                        rem_d   = r_neg_q ? -prem_step : prem_step;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Gated by rstN so upstream is never held while the block sits in reset.
    assign stallReq  = rstN & (((state_q == S_IDLE) & start & ~cancel) | (state_q == S_BUSY));
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed bench for ex_div_sequencer: latency, signed/unsigned results,
// divide-by-zero, overflow, cancel, back-to-back and mid-operation reset.
module tb_ex_div_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        signedOp;
    logic        cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stallReq;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp = 0;
    int n_bad = 0;

    ex_div_sequencer #(.WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .signedOp  (signedOp),
        .cancel    (cancel),
        .dividend  (dividend),
        .divisor   (divisor),
        .stallReq  (stallReq),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts an op on the next cycle (cycle 0), holds start until done is seen,
    // then drops start inside the DONE cycle. Returns at the negedge of that cycle.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_q, input logic [31:0] exp_r);
        int done_cyc   = -1;
        int last_stall = -1;
        int stall_cnt  = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        cancel   = 1'b0;
        signedOp = sgn;
        dividend = a;
        divisor  = b;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stallReq) begin
                stall_cnt++;
                last_stall = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " stall_cycles"}, stall_cnt, exp_cyc);
        check({tag, " last_stall"}, last_stall, exp_cyc - 1);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
    endtask

    initial begin
        rstN     = 1'b0;
        start    = 1'b1;
        signedOp = 1'b0;
        cancel   = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        #12;
        check("reset stall", {31'b0, stallReq}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rstN = 1'b1;

        // 1: unsigned baseline, then confirm done is a single-cycle pulse
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pulse_width", {31'b0, done}, 32'd0);
        check("idle_stall", {31'b0, stallReq}, 32'd0);

        // 2: signed sign handling and unsigned full-range dividend
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        run_op("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 33, 32'h7FFF_FFFF, 32'd1);
        run_op("divu_max_maxm1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32'd1, 32'd1);

        // 3: divide by zero short-cuts to DONE with defined zero results
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 1, 32'd0, 32'd0);

        // 4: INT_MIN / -1 wraps without a trap
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // 5: cancel mid-operation, then cancel beating start in IDLE
        @(posedge clk); #1;
        start    = 1'b1;
        signedOp = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (10) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_c10_stall", {31'b0, stallReq}, 32'd1);
        check("cancel_c10_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("cancel_c11_stall", {31'b0, stallReq}, 32'd0);
        check("cancel_c11_done", {31'b0, done}, 32'd0);
        check("cancel_c11_quotient", quotient, 32'h8000_0000);
        check("cancel_c11_remainder", remainder, 32'd0);
        run_op("divu_9_3_after_cancel", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

        // 6: back-to-back ops with no bubble, then reset during a third op
        run_op("b2b_9_4", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1);
        run_op("b2b_8_3", 1'b0, 32'd8, 32'd3, 33, 32'd2, 32'd2);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rstN = 1'b0;
        #1;
        check("midrst_stall", {31'b0, stallReq}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("post_rst_stall", {31'b0, stallReq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
